// File: rtl/relu_pack_buf_pkg.sv
// Shared PE-stream types plus the writeback packer defaults.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

package relu_pack_buf_pkg;

    // State tag carried alongside every PE output sample.
    typedef enum logic [2:0] {
        INVALID  = 3'd0,
        VALID    = 3'd1,
        CNN_FIN  = 3'd2,
        POOL_FIN = 3'd3,
        COMPL    = 3'd4
    } pe_state_t;

    // Registered output packet of the pooling stage.
    typedef struct packed {
        pe_state_t                    PE_state;
        logic signed [`CNN_XLEN-1:0]  data;
    } PE_OUT_PACKET;

    localparam int RELU_OUT_WID  = 8;
    localparam int RELU_PACK_NUM = 4;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; DEPTH must be a power of two >= 2.
// A push while full is only accepted when a pop happens on the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_en    = pop && !empty;
    assign wr_en    = push && (!full || rd_en);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/relu_pack_buf.sv
// ReLU + requantise + saturate each pooled result, pack lanes into words and
// buffer them behind a valid/ready interface so writeback can stall freely.
`ifndef CNN_XLEN
`define CNN_XLEN 16
`endif

module relu_pack_buf
    import relu_pack_buf_pkg::*;
#(
    parameter int DATA_WID   = `CNN_XLEN,
    parameter int OUT_WID    = RELU_OUT_WID,
    parameter int SHIFT      = 0,
    parameter int PACK_NUM   = RELU_PACK_NUM,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  PE_OUT_PACKET                  relu_in_pk,
    output logic [PACK_NUM*OUT_WID-1:0]   out_data,
    output logic [$clog2(PACK_NUM+1)-1:0] out_cnt,
    output logic                          out_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow,
    output logic                          busy
);

    localparam int CNT_W   = $clog2(PACK_NUM + 1);
    localparam int WORD_W  = PACK_NUM * OUT_WID;
    localparam int ENTRY_W = 1 + CNT_W + WORD_W;
    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(PACK_NUM - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(PACK_NUM);

    // Negative values clamp to zero; large values saturate to all ones.
    function automatic logic [OUT_WID-1:0] relu_quant(input logic signed [DATA_WID-1:0] d);
        logic [DATA_WID-1:0] sh;
        if (d < 0) return '0;
        sh = DATA_WID'(d >>> SHIFT);
        if ((sh >> OUT_WID) != '0) return '1;
        return OUT_WID'(sh);
    endfunction

    logic signed [DATA_WID-1:0] data_in;
    logic [OUT_WID-1:0]         lane_val;
    logic                       is_pool;
    logic                       is_compl;
    logic [CNT_W-1:0]           lane_cnt;
    logic [WORD_W-1:0]          pack_reg;
    logic [WORD_W-1:0]          merged;
    logic                       push;
    logic [ENTRY_W-1:0]         push_entry;
    logic [ENTRY_W-1:0]         head_entry;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       pop;

    assign data_in  = relu_in_pk.data;
    assign lane_val = relu_quant(data_in);
    assign is_pool  = (relu_in_pk.PE_state == POOL_FIN);
    assign is_compl = (relu_in_pk.PE_state == COMPL);

    // Pack register with the incoming lane dropped into its slot.
    always_comb begin
        merged = pack_reg;
        merged[lane_cnt*OUT_WID +: OUT_WID] = lane_val;
    end

    // Decide whether this edge emits a word: full word on the last lane, or a
    // partial/marker word with the last flag on COMPL.
    always_comb begin
        push       = 1'b0;
        push_entry = '0;
        if (is_pool && (lane_cnt == LAST_LANE)) begin
            push       = 1'b1;
            push_entry = {1'b0, FULL_CNT, merged};
        end else if (is_compl) begin
            push       = 1'b1;
            push_entry = {1'b1, lane_cnt, pack_reg};
        end
    end

    // Lane accumulation; the register clears whenever a word leaves, even if dropped.
    always_ff @(posedge clk) begin
        if (!reset) begin
            lane_cnt <= '0;
            pack_reg <= '0;
        end else if (is_pool) begin
            if (lane_cnt == LAST_LANE) begin
                lane_cnt <= '0;
                pack_reg <= '0;
            end else begin
                lane_cnt <= lane_cnt + 1'b1;
                pack_reg <= merged;
            end
        end else if (is_compl) begin
            lane_cnt <= '0;
            pack_reg <= '0;
        end
    end

    // Sticky flag for a word lost to a full FIFO with no simultaneous pop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .full      (fifo_full),
        .pop       (pop),
        .pop_data  (head_entry),
        .empty     (fifo_empty)
    );

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign {out_last, out_cnt, out_data} = fifo_empty ? '0 : head_entry;
    assign busy      = (lane_cnt != '0) || !fifo_empty;

endmodule
